// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path.
// Holds the control-FSM status encodings (also used by the command
// generator to decide start vs stop) and the default debounce length.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_INVALID = 2'b11
  } status_e;

  // Short enough for simulation; board builds override via parameter.
  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioning chain: 2-flop synchroniser, debouncer and
// rising-edge detector.
//   clk, rst   : system clock, synchronous active-high reset
//   btn_raw    : raw asynchronous button, active-high
//   press_evt  : high for one cycle after a debounced 0->1 transition
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter tracks how long the synchronised input has disagreed with the
  // debounced state; any agreement restarts it. Reaching DEBOUNCE_CYCLES
  // flips the state and the counter returns to 0, so it never exceeds
  // DEBOUNCE_CYCLES-1 between edges.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = ~deb_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      cnt_q   <= cnt_d;
    end
  end

  // Combinational edge detect; the top registers the resulting command.
  assign press_evt = deb_q & ~prev_q;

endmodule

// File: rtl/stopwatch_cmd_gen.sv
// Stopwatch command generator: conditions the start/stop toggle and reset
// buttons and emits single-cycle start/stop/reset commands for the control
// FSM. Toggle meaning is chosen from the FSM status sampled at the same
// edge that registers the command.
//   clk, rst     : system clock, synchronous active-high reset
//   btn_ss_raw   : raw start/stop toggle button
//   btn_rst_raw  : raw reset button
//   status       : FSM state (IDLE/RUNNING/PAUSED, 11 invalid)
//   start/stop/reset : one-cycle command pulses, mutually exclusive
module stopwatch_cmd_gen
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss_raw,
  input  logic       btn_rst_raw,
  input  logic [1:0] status,
  output logic       start,
  output logic       stop,
  output logic       reset
);

  logic ss_evt, rs_evt;
  logic start_d, stop_d, reset_d;
  logic start_q, stop_q, reset_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_ss_raw),
    .press_evt (ss_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rs (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_rst_raw),
    .press_evt (rs_evt)
  );

  // Reset wins over a coincident toggle; a toggle with invalid status is
  // dropped rather than guessed at.
  always_comb begin
    start_d = 1'b0;
    stop_d  = 1'b0;
    reset_d = 1'b0;
    if (rs_evt) begin
      reset_d = 1'b1;
    end else if (ss_evt) begin
      case (status_e'(status))
        ST_IDLE, ST_PAUSED: start_d = 1'b1;
        ST_RUNNING:         stop_d  = 1'b1;
        default:            ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
      reset_q <= reset_d;
    end
  end

  assign start = start_q;
  assign stop  = stop_q;
  assign reset = reset_q;

endmodule

// File: tb/tb_stopwatch_cmd_gen.sv
// Bench for stopwatch_cmd_gen (DEBOUNCE_CYCLES=4): directed scenarios plus
// random button/status/reset traffic against a window-based reference model.
module tb_stopwatch_cmd_gen;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, ss, rr;
  logic [1:0] status;
  logic       start, stop, reset;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_cmd_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_ss_raw  (ss),
    .btn_rst_raw (rr),
    .status      (status),
    .start       (start),
    .stop        (stop),
    .reset       (reset)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model. Index 0 = toggle button, 1 = reset button.
  // A debounced state flips once the last D synchronised samples all
  // disagree with it; a press event is a flip to 1. Command bits are
  // {start,stop,reset}.
  bit         m_s1[2], m_s2[2], m_deb[2], pend[2];
  bit         win0[$], win1[$];
  logic [2:0] m_out;

  task automatic win_step(input int b, input bit smp, output bit flip);
    bit all_diff;
    if (b == 0) begin
      win0.push_back(smp);
      if (win0.size() > D) void'(win0.pop_front());
    end else begin
      win1.push_back(smp);
      if (win1.size() > D) void'(win1.pop_front());
    end
    all_diff = ((b == 0) ? win0.size() : win1.size()) == D;
    for (int k = 0; k < D && all_diff; k++)
      if (((b == 0) ? win0[k] : win1[k]) == m_deb[b]) all_diff = 0;
    flip = all_diff;
  endtask

  task automatic model_edge();
    bit raw[2];
    bit fl;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; pend[b] = 0;
      end
      win0.delete();
      win1.delete();
      m_out = 3'b000;
      return;
    end
    if (pend[1])      m_out = 3'b001;
    else if (pend[0]) m_out = (status == 2'b01) ? 3'b010 :
                              (status == 2'b11) ? 3'b000 : 3'b100;
    else              m_out = 3'b000;
    raw[0] = ss;
    raw[1] = rr;
    for (int b = 0; b < 2; b++) begin
      win_step(b, m_s2[b], fl);
      pend[b] = 0;
      if (fl) begin
        m_deb[b] = ~m_deb[b];
        pend[b]  = m_deb[b];
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  // One clock: model follows the edge, DUT is sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, {29'd0, start, stop, reset}, {29'd0, m_out});
  endtask

  task automatic do_reset();
    rst = 1; ss = 0; rr = 0;
    step("rst_a");
    step("rst_b");
    rst = 0;
  endtask

  // Drives toggle high from edge 1 for 20 edges; checks the single pulse
  // lands after edge 7 with the expected command bits.
  task automatic press_hold(input string tag, input logic [1:0] st, input logic [2:0] exp7);
    int pulses;
    do_reset();
    status = st; ss = 1;
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      step(tag);
      if ({start, stop, reset} != 3'b000) pulses++;
      if (e == 7) chk({tag, "_e7"}, {29'd0, start, stop, reset}, {29'd0, exp7});
    end
    chk({tag, "_npulse"}, pulses, (exp7 == 3'b000) ? 0 : 1);
    ss = 0;
  endtask

  initial begin
    int hold[2];
    int pulses;
    rst = 1; ss = 0; rr = 0; status = 2'b00;
    do_reset();
    chk("reset_state", {29'd0, start, stop, reset}, 32'd0);

    // 1, 2: toggle held with each status
    press_hold("t1_idle",    2'b00, 3'b100);
    press_hold("t2_running", 2'b01, 3'b010);
    press_hold("t2_invalid", 2'b11, 3'b000);
    press_hold("t2_paused",  2'b10, 3'b100);

    // 3: bounce 3 high / 1 low / 3 high, then hold
    do_reset();
    status = 2'b00;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      ss = (i != 3);
      step("t3_bounce");
      if (start) pulses++;
    end
    ss = 0;
    for (int i = 0; i < 3; i++) begin step("t3_bounce"); if (start) pulses++; end
    chk("t3_bounce_none", pulses, 0);
    ss = 1;
    for (int i = 0; i < 12; i++) begin step("t3_hold"); if (start) pulses++; end
    chk("t3_one_start", pulses, 1);
    ss = 0;

    // 4: both buttons together, status PAUSED -> reset only
    do_reset();
    status = 2'b10; ss = 1; rr = 1;
    pulses = 0;
    for (int e = 1; e <= 12; e++) begin
      step("t4_both");
      if (start) pulses++;
      if (e == 7) chk("t4_reset_e7", {31'd0, reset}, 32'd1);
    end
    chk("t4_no_start", pulses, 0);
    ss = 0; rr = 0;

    // 5: press, release, press again with status moving IDLE -> RUNNING
    do_reset();
    status = 2'b00; ss = 1;
    for (int i = 0; i < 10; i++) step("t5_p1");
    ss = 0;
    for (int i = 0; i < 10; i++) step("t5_rel");
    status = 2'b01; ss = 1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin step("t5_p2"); if (stop) pulses++; end
    chk("t5_one_stop", pulses, 1);
    ss = 0;

    // 6: rst at edges 6-7 mid press; pulse only after edge 14
    do_reset();
    status = 2'b00; ss = 1;
    for (int e = 1; e <= 20; e++) begin
      rst = (e == 6 || e == 7);
      step("t6_midrst");
      if (e == 6) chk("t6_zero_e6", {29'd0, start, stop, reset}, 32'd0);
      if (e == 7) chk("t6_none_e7", {31'd0, start}, 32'd0);
      if (e == 14) chk("t6_start_e14", {31'd0, start}, 32'd1);
    end
    rst = 0; ss = 0;

    // Random traffic: runs of random length per button, random status,
    // occasional reset.
    do_reset();
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (hold[b] == 0) begin
          hold[b] = $urandom_range(1, 9);
          if (b == 0) ss = $urandom_range(0, 1);
          else        rr = ($urandom_range(0, 3) == 0);
        end
        hold[b]--;
      end
      status = $urandom_range(0, 3);
      rst    = ($urandom_range(0, 149) == 0);
      step("rand");
      chk("rand_onehot", {31'd0, $onehot0({start, stop, reset})}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
